// File: rtl/hdmi_tx_pkg.sv
// hdmi_tx_pkg: CEA-861 timing table, ACR N lookup and ideal CTS derivation.
// Everything here is evaluated at elaboration; the real arithmetic never reaches hardware.
package hdmi_tx_pkg;

  typedef struct packed {
    logic [11:0] h_active;
    logic [11:0] h_total;
    logic [11:0] h_fp;
    logic [11:0] h_sync;
    logic [10:0] v_active;
    logic [10:0] v_total;
    logic [10:0] v_fp;
    logic [10:0] v_sync;
    logic        sync_pos;
  } vic_timing_t;

  function automatic bit vic_supported(input int vic);
    return (vic == 1) || (vic == 4) || (vic == 16) || (vic == 17);
  endfunction

  function automatic vic_timing_t vic_timing(input int vic);
    vic_timing_t t;
    case (vic)
      4:       t = '{12'd1280, 12'd1650, 12'd110, 12'd40, 11'd720,  11'd750,  11'd5,  11'd5, 1'b1};
      16:      t = '{12'd1920, 12'd2200, 12'd88,  12'd44, 11'd1080, 11'd1125, 11'd4,  11'd5, 1'b1};
      17:      t = '{12'd720,  12'd864,  12'd12,  12'd64, 11'd576,  11'd625,  11'd5,  11'd5, 1'b0};
      default: t = '{12'd640,  12'd800,  12'd16,  12'd96, 11'd480,  11'd525,  11'd10, 11'd2, 1'b0};
    endcase
    return t;
  endfunction

  // Returns 0 for an unsupported rate so the top can reject it.
  function automatic int n_lookup(input int fs);
    int n;
    case (fs)
      32000:   n = 4096;
      44100:   n = 6272;
      48000:   n = 6144;
      88200:   n = 12544;
      96000:   n = 12288;
      176400:  n = 25088;
      192000:  n = 24576;
      default: n = 0;
    endcase
    return n;
  endfunction

  function automatic real pixel_clock_hz(input int vic, input real refresh);
    real f;
    case (vic)
      4:       f = 74.25e6;
      16:      f = 148.5e6;
      17:      f = 27.0e6;
      default: f = 25.2e6;
    endcase
    // 50 Hz formats have no fractional-rate variant.
    if ((vic != 17) && (refresh < 59.97)) f = f / 1.001;
    return f;
  endfunction

  function automatic int cts_ideal(input int vic, input int fs, input real refresh);
    real cts;
    cts = pixel_clock_hz(vic, refresh) * real'(n_lookup(fs)) / (128.0 * real'(fs));
    return $rtoi(cts + 0.5);
  endfunction

endpackage

// File: rtl/hdmi_tx_acr.sv
// hdmi_tx_acr: audio-sample counter and CTS measurement for Audio Clock Regeneration.
// HDMI_ACR_MEASURE_EN selects the measured CTS; otherwise the ideal constant is sent.
module hdmi_tx_acr #(
  parameter int          N_DIV     = 48,
  parameter logic [19:0] CTS_IDEAL = 20'd25200
) (
  input  logic        clk_pixel,
  input  logic        reset_n,
  input  logic        audio_tick,
  output logic [19:0] acr_cts,
  output logic        acr_valid
);
  localparam int            AW     = $clog2(N_DIV);
  localparam logic [AW-1:0] A_LAST = AW'(N_DIV - 1);

  logic [AW-1:0] audio_cnt_q, audio_cnt_d;
  logic          acr_valid_q, acr_valid_d;
  logic          wrap;

  assign wrap = audio_tick && (audio_cnt_q == A_LAST);

  always_comb begin
    audio_cnt_d = audio_cnt_q;
    if (audio_tick) audio_cnt_d = wrap ? '0 : audio_cnt_q + AW'(1);
    acr_valid_d = wrap;
  end

  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      audio_cnt_q <= '0;
      acr_valid_q <= 1'b0;
    end else begin
      audio_cnt_q <= audio_cnt_d;
      acr_valid_q <= acr_valid_d;
    end
  end

  assign acr_valid = acr_valid_q;

`ifdef HDMI_ACR_MEASURE_EN
  logic [19:0] cycle_cnt_q, cycle_cnt_d;
  logic [19:0] acr_cts_q, acr_cts_d;
  logic [19:0] cycle_inc;

  // Saturating so a stalled audio source cannot alias to a small CTS.
  assign cycle_inc = (cycle_cnt_q == '1) ? cycle_cnt_q : cycle_cnt_q + 20'd1;

  always_comb begin
    cycle_cnt_d = wrap ? '0 : cycle_inc;
    acr_cts_d   = wrap ? cycle_inc : acr_cts_q;
  end

  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      cycle_cnt_q <= '0;
      acr_cts_q   <= CTS_IDEAL;
    end else begin
      cycle_cnt_q <= cycle_cnt_d;
      acr_cts_q   <= acr_cts_d;
    end
  end

  assign acr_cts = acr_cts_q;
`else
  assign acr_cts = CTS_IDEAL;
`endif

endmodule

// File: rtl/hdmi_tx.sv
// hdmi_tx: CEA-861 video timing generator plus ACR N/CTS source.
// Define HDMI_ACR_MEASURE_EN to send the measured CTS instead of the ideal constant.
module hdmi_tx
  import hdmi_tx_pkg::*;
#(
  parameter int  VIDEO_ID_CODE      = 1,
  parameter int  AUDIO_RATE         = 48000,
  parameter real VIDEO_REFRESH_RATE = 59.94
) (
  input  logic        clk_pixel,
  input  logic        reset_n,
  input  logic        audio_tick,
  output logic [11:0] cx,
  output logic [10:0] cy,
  output logic        video_active,
  output logic        hsync,
  output logic        vsync,
  output logic [19:0] acr_n,
  output logic [19:0] acr_cts,
  output logic        acr_valid
);
  localparam vic_timing_t TIMING = vic_timing(VIDEO_ID_CODE);
  localparam int          N_VALUE = n_lookup(AUDIO_RATE);
  localparam logic [19:0] CTS_IDEAL = 20'(cts_ideal(VIDEO_ID_CODE, AUDIO_RATE, VIDEO_REFRESH_RATE));

  localparam logic [11:0] H_ACTIVE = TIMING.h_active;
  localparam logic [11:0] H_LAST   = TIMING.h_total - 12'd1;
  localparam logic [11:0] HS_START = TIMING.h_active + TIMING.h_fp;
  localparam logic [11:0] HS_END   = HS_START + TIMING.h_sync;
  localparam logic [10:0] V_ACTIVE = TIMING.v_active;
  localparam logic [10:0] V_LAST   = TIMING.v_total - 11'd1;
  localparam logic [10:0] VS_START = TIMING.v_active + TIMING.v_fp;
  localparam logic [10:0] VS_END   = VS_START + TIMING.v_sync;
  localparam logic        SYNC_POS = TIMING.sync_pos;

  if (!vic_supported(VIDEO_ID_CODE)) begin : g_bad_vic
    $error("hdmi_tx: unsupported VIDEO_ID_CODE %0d", VIDEO_ID_CODE);
  end
  if (N_VALUE == 0) begin : g_bad_rate
    $error("hdmi_tx: unsupported AUDIO_RATE %0d", AUDIO_RATE);
  end

  logic [11:0] cx_q, cx_d;
  logic [10:0] cy_q, cy_d;
  logic        hs_on, vs_on;

  always_comb begin
    cx_d = cx_q + 12'd1;
    cy_d = cy_q;
    if (cx_q == H_LAST) begin
      cx_d = '0;
      cy_d = (cy_q == V_LAST) ? '0 : cy_q + 11'd1;
    end
  end

  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      cx_q <= '0;
      cy_q <= '0;
    end else begin
      cx_q <= cx_d;
      cy_q <= cy_d;
    end
  end

  // Decoded straight from the counters so they line up with cx/cy on the same cycle.
  always_comb begin
    hs_on        = (cx_q >= HS_START) && (cx_q < HS_END);
    vs_on        = (cy_q >= VS_START) && (cy_q < VS_END);
    video_active = (cx_q < H_ACTIVE) && (cy_q < V_ACTIVE);
    hsync        = SYNC_POS ? hs_on : !hs_on;
    vsync        = SYNC_POS ? vs_on : !vs_on;
  end

  assign cx    = cx_q;
  assign cy    = cy_q;
  assign acr_n = 20'(N_VALUE);

  hdmi_tx_acr #(
    .N_DIV     (N_VALUE / 128),
    .CTS_IDEAL (CTS_IDEAL)
  ) u_acr (
    .clk_pixel  (clk_pixel),
    .reset_n    (reset_n),
    .audio_tick (audio_tick),
    .acr_cts    (acr_cts),
    .acr_valid  (acr_valid)
  );

endmodule

// File: tb/tb_hdmi_tx.sv
// tb_hdmi_tx: six hdmi_tx elaborations sharing one clock, reset and audio tick,
// checked against a frame/tick-count model built from the timing and ACR rules.
module tb_hdmi_tx;
  localparam int NI      = 6;
  localparam int CYC_MAX = 1048575;

  logic clk        = 1'b0;
  logic reset_n    = 1'b0;
  logic audio_tick = 1'b0;

  logic [11:0] cx_o  [NI];
  logic [10:0] cy_o  [NI];
  logic        va_o  [NI];
  logic        hs_o  [NI];
  logic        vs_o  [NI];
  logic [19:0] n_o   [NI];
  logic [19:0] cts_o [NI];
  logic        val_o [NI];

  int total = 0;
  int bad   = 0;

  // Per-instance expectations: VIC, ideal CTS, N and which ACR tick group it follows.
  int vic_of   [NI] = '{1, 1, 4, 16, 17, 1};
  int ideal_of [NI] = '{25175, 25200, 74176, 148500, 27000, 28000};
  int nval_of  [NI] = '{6144, 6144, 6144, 6144, 6144, 6272};
  int grp_of   [NI] = '{0, 0, 0, 0, 0, 1};
  int ndiv     [2]  = '{6144 / 128, 6272 / 128};

  int n_edges;
  int ticks [2];
  int cyc [2];
  int cap [2];
  int mpulses [2] = '{0, 0};
  bit exp_pulse [2];
  int dut_pulses [NI] = '{0, 0, 0, 0, 0, 0};
  int exp_cts [NI];
  bit vid_every = 1'b0;

  always #5 clk = ~clk;

  hdmi_tx #(.VIDEO_ID_CODE(1), .AUDIO_RATE(48000), .VIDEO_REFRESH_RATE(59.94)) u_v1_5994 (
    .clk_pixel(clk), .reset_n(reset_n), .audio_tick(audio_tick), .cx(cx_o[0]), .cy(cy_o[0]),
    .video_active(va_o[0]), .hsync(hs_o[0]), .vsync(vs_o[0]), .acr_n(n_o[0]), .acr_cts(cts_o[0]), .acr_valid(val_o[0]));
  hdmi_tx #(.VIDEO_ID_CODE(1), .AUDIO_RATE(48000), .VIDEO_REFRESH_RATE(60.0)) u_v1_60 (
    .clk_pixel(clk), .reset_n(reset_n), .audio_tick(audio_tick), .cx(cx_o[1]), .cy(cy_o[1]),
    .video_active(va_o[1]), .hsync(hs_o[1]), .vsync(vs_o[1]), .acr_n(n_o[1]), .acr_cts(cts_o[1]), .acr_valid(val_o[1]));
  hdmi_tx #(.VIDEO_ID_CODE(4), .AUDIO_RATE(48000), .VIDEO_REFRESH_RATE(59.94)) u_v4_5994 (
    .clk_pixel(clk), .reset_n(reset_n), .audio_tick(audio_tick), .cx(cx_o[2]), .cy(cy_o[2]),
    .video_active(va_o[2]), .hsync(hs_o[2]), .vsync(vs_o[2]), .acr_n(n_o[2]), .acr_cts(cts_o[2]), .acr_valid(val_o[2]));
  hdmi_tx #(.VIDEO_ID_CODE(16), .AUDIO_RATE(48000), .VIDEO_REFRESH_RATE(60.0)) u_v16_60 (
    .clk_pixel(clk), .reset_n(reset_n), .audio_tick(audio_tick), .cx(cx_o[3]), .cy(cy_o[3]),
    .video_active(va_o[3]), .hsync(hs_o[3]), .vsync(vs_o[3]), .acr_n(n_o[3]), .acr_cts(cts_o[3]), .acr_valid(val_o[3]));
  hdmi_tx #(.VIDEO_ID_CODE(17), .AUDIO_RATE(48000), .VIDEO_REFRESH_RATE(60.0)) u_v17 (
    .clk_pixel(clk), .reset_n(reset_n), .audio_tick(audio_tick), .cx(cx_o[4]), .cy(cy_o[4]),
    .video_active(va_o[4]), .hsync(hs_o[4]), .vsync(vs_o[4]), .acr_n(n_o[4]), .acr_cts(cts_o[4]), .acr_valid(val_o[4]));
  hdmi_tx #(.VIDEO_ID_CODE(1), .AUDIO_RATE(44100), .VIDEO_REFRESH_RATE(60.0)) u_v1_44k (
    .clk_pixel(clk), .reset_n(reset_n), .audio_tick(audio_tick), .cx(cx_o[5]), .cy(cy_o[5]),
    .video_active(va_o[5]), .hsync(hs_o[5]), .vsync(vs_o[5]), .acr_n(n_o[5]), .acr_cts(cts_o[5]), .acr_valid(val_o[5]));

  // Expected {cx, cy, video_active, hsync, vsync} after n clocks since reset release.
  function automatic logic [25:0] exp_video(input int vic, input int n);
    int w, h, fw, fh, hs0, hsl, vs0, vsl, x, y;
    bit pos, hs_on, vs_on, act;
    case (vic)
      4:       begin w = 1280; h = 720;  fw = 1650; fh = 750;  hs0 = 1280 + 110; hsl = 40; vs0 = 720 + 5;  vsl = 5; pos = 1'b1; end
      16:      begin w = 1920; h = 1080; fw = 2200; fh = 1125; hs0 = 1920 + 88;  hsl = 44; vs0 = 1080 + 4; vsl = 5; pos = 1'b1; end
      17:      begin w = 720;  h = 576;  fw = 864;  fh = 625;  hs0 = 720 + 12;   hsl = 64; vs0 = 576 + 5;  vsl = 5; pos = 1'b0; end
      default: begin w = 640;  h = 480;  fw = 800;  fh = 525;  hs0 = 640 + 16;   hsl = 96; vs0 = 480 + 10; vsl = 2; pos = 1'b0; end
    endcase
    x = n % fw;
    y = (n / fw) % fh;
    hs_on = (x >= hs0) && (x < hs0 + hsl);
    vs_on = (y >= vs0) && (y < vs0 + vsl);
    act   = (x < w) && (y < h);
    return {12'(x), 11'(y), act, hs_on == pos, vs_on == pos};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed 'h%0h expected 'h%0h", tag, obs, exp);
    end
  endtask

  task automatic check_video();
    for (int i = 0; i < NI; i++)
      check($sformatf("video[%0d] n=%0d", i, n_edges),
            64'({cx_o[i], cy_o[i], va_o[i], hs_o[i], vs_o[i]}),
            64'(exp_video(vic_of[i], n_edges)));
  endtask

  // One clock: drive tick, advance the model at the edge, sample at the falling edge.
  task automatic clk_step(input logic tick);
    audio_tick = tick;
    @(posedge clk);
    for (int g = 0; g < 2; g++) exp_pulse[g] = 1'b0;
    if (reset_n) begin
      n_edges++;
      for (int g = 0; g < 2; g++) begin
        if (cyc[g] < CYC_MAX) cyc[g]++;
        if (tick) begin
          ticks[g]++;
          if (ticks[g] == ndiv[g]) begin
            ticks[g]     = 0;
            exp_pulse[g] = 1'b1;
            cap[g]       = cyc[g];
            cyc[g]       = 0;
            mpulses[g]++;
          end
        end
      end
    end
    @(negedge clk);
    for (int g = 0; g < 2; g++)
      if (exp_pulse[g]) $display("acr wrap: group=%0d cycles=%0d edge=%0d", g, cap[g], n_edges);
    for (int i = 0; i < NI; i++) begin
      if (val_o[i]) dut_pulses[i]++;
      if (exp_pulse[grp_of[i]]) begin
`ifdef HDMI_ACR_MEASURE_EN
        exp_cts[i] = cap[grp_of[i]];
`endif
        check($sformatf("acr_valid[%0d]", i), 64'(val_o[i]), 64'(1));
        check($sformatf("acr_cts[%0d]", i), 64'(cts_o[i]), 64'(exp_cts[i]));
      end
    end
    if (vid_every || (n_edges % 97 == 0)) check_video();
  endtask

  task automatic do_reset(input int cycles, input bit async_chk);
    reset_n = 1'b0;
    n_edges = 0;
    for (int g = 0; g < 2; g++) begin
      ticks[g] = 0;
      cyc[g]   = 0;
    end
    for (int i = 0; i < NI; i++) exp_cts[i] = ideal_of[i];
    #1;
    if (async_chk)
      for (int i = 0; i < NI; i++)
        check($sformatf("async reset cts[%0d]", i), 64'(cts_o[i]), 64'(ideal_of[i]));
    repeat (cycles) clk_step(1'b0);
    for (int i = 0; i < NI; i++) begin
      check($sformatf("reset acr_n[%0d]", i), 64'(n_o[i]), 64'(nval_of[i]));
      check($sformatf("reset acr_cts[%0d]", i), 64'(cts_o[i]), 64'(ideal_of[i]));
      check($sformatf("reset acr_valid[%0d]", i), 64'(val_o[i]), 64'(0));
    end
    check_video();
    reset_n = 1'b1;
  endtask

  task automatic check_phase(input string ph);
    for (int i = 0; i < NI; i++) begin
      check($sformatf("%s cts[%0d]", ph, i), 64'(cts_o[i]), 64'(exp_cts[i]));
      check($sformatf("%s pulses[%0d]", ph, i), 64'(dut_pulses[i]), 64'(mpulses[grp_of[i]]));
    end
  endtask

  initial begin
    int s0, s1, cycles, gap;

    do_reset(4, 1'b0);

    // Steady 525-clock tick period; first 2400 clocks also check video every cycle.
    vid_every = 1'b1;
    for (int i = 1; i <= 48 * 525; i++) begin
      clk_step(i % 525 == 0);
      if (i == 2400) vid_every = 1'b0;
    end
    check_phase("period525");
`ifdef HDMI_ACR_MEASURE_EN
    check("period525 vic1_60 measured", 64'(cts_o[1]), 64'(25200));
    check("period525 vic1_5994 measured", 64'(cts_o[0]), 64'(25200));
`else
    check("period525 vic1_5994 ideal", 64'(cts_o[0]), 64'(25175));
`endif

    for (int i = 1; i <= 48 * 524; i++) clk_step(i % 524 == 0);
    check_phase("period524");
`ifdef HDMI_ACR_MEASURE_EN
    check("period524 vic1_5994 measured", 64'(cts_o[0]), 64'(25152));
`else
    check("period524 vic1_5994 ideal", 64'(cts_o[0]), 64'(25175));
`endif

    // Abandon a measurement partway through.
    for (int i = 1; i <= 20 * 300; i++) clk_step(i % 300 == 0);
    do_reset(3, 1'b1);

    for (int i = 1; i <= 48 * 100; i++) clk_step(i % 100 == 0);
    check_phase("after reset");
`ifdef HDMI_ACR_MEASURE_EN
    check("after reset vic1_5994 measured", 64'(cts_o[0]), 64'(4800));
`else
    check("after reset vic1_5994 ideal", 64'(cts_o[0]), 64'(25175));
`endif

    // Random gaps, including back-to-back ticks, until both groups wrap twice.
    s0 = mpulses[0];
    s1 = mpulses[1];
    cycles = 0;
    while (((mpulses[0] - s0) < 2 || (mpulses[1] - s1) < 2) && cycles < 30000) begin
      gap = ($urandom_range(3, 0) == 0) ? 1 : int'($urandom_range(200, 2));
      for (int j = 1; j < gap; j++) clk_step(1'b0);
      clk_step(1'b1);
      cycles += gap;
    end
    check("random phase wraps within budget",
          64'(((mpulses[0] - s0) >= 2) && ((mpulses[1] - s1) >= 2)), 64'(1));
    repeat (2) clk_step(1'b0);
    check_phase("random");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hdmi_tx.md
# hdmi_tx

Compact HDMI source core for the hdmi path: pixel-clock video timing generator plus Audio Clock Regeneration (ACR) N/CTS generation. Timing is selected by CEA-861 VIC at elaboration; N and the ideal CTS are elaboration-time constants derived from VIC, audio rate and refresh rate. A measured CTS is produced at runtime from an audio-rate tick. TMDS encoding and packet assembly sit downstream and are out of scope.

## Interface
- VIDEO_ID_CODE, 1: VIC; supported 1, 4, 16, 17; any other value is an elaboration error.
- AUDIO_RATE, 48000: fs in Hz; one of 32000, 44100, 48000, 88200, 96000, 176400, 192000.
- VIDEO_REFRESH_RATE (real), 59.94: 59.94 or 60; ignored for 50 Hz VICs (17).

- clk_pixel  in  1  pixel clock, sole clock.
- reset_n  in  1  asynchronous, active-low reset.
- audio_tick  in  1  one-cycle pulse per audio sample, already in clk_pixel domain.
- cx  out  12  horizontal counter.
- cy  out  11  vertical counter.
- video_active  out  1  cx < W and cy < H.
- hsync, vsync  out  1  sync, VIC polarity applied.
- acr_n  out  20  constant N.
- acr_cts  out  20  CTS (measured or ideal, see Configuration).
- acr_valid  out  1  one-cycle pulse when acr_cts updates.

## Operation
- Timing (active W×H, frame, hfp/hs/hbp, vfp/vs/vbp, polarity): VIC1 640×480, 800×525, 16/96/48, 10/2/33, neg; VIC4 1280×720, 1650×750, 110/40/220, 5/5/20, pos; VIC16 1920×1080, 2200×1125, 88/44/148, 4/5/36, pos; VIC17 720×576, 864×625, 12/64/68, 5/5/39, neg.
- cx increments each clock, wraps frame_width-1→0; on wrap cy increments, wraps frame_height-1→0.
- hsync active for cx in [W+hfp, W+hfp+hs); vsync active for cy in [H+vfp, H+vfp+vs), full lines; inactive level = inverse of active.
- Base pixel clock: VIC1 25.2 MHz, VIC4 74.25, VIC16 148.5, VIC17 27. For 60 Hz-family VICs with VIDEO_REFRESH_RATE 59.94, divide by 1.001.
- N table: 32k 4096, 44.1k 6272, 48k 6144, 88.2k 12544, 96k 12288, 176.4k 25088, 192k 24576.
- CTS_IDEAL = round-to-nearest(f_pixel·N / (128·fs)). Examples at 48 kHz: VIC1/60 25200, VIC1/59.94 25175, VIC4/59.94 74176, VIC16/60 148500, VIC17 27000.
- Audio counter counts audio_tick modulo N/128; wrap event when a tick arrives at count N/128-1.
- Cycle counter (20 b) increments every clock, saturating at 2^20-1; on wrap event: captured = counter+1 (saturating), counter←0.

## Timing
- Reset: cx=0, cy=0, video_active=1, syncs inactive, acr_cts=CTS_IDEAL, acr_valid=0, both ACR counters 0; acr_n constant.
- cx/cy registered; video_active/hsync/vsync combinational from cx/cy (zero latency).
- acr_cts updates and acr_valid pulses the clock after the wrap-event tick is sampled.
- audio_tick on consecutive clocks: each counts. Reset mid-measurement discards the partial count.

## Configuration
- HDMI_ACR_MEASURE_EN defined: acr_cts = captured measured value.
- Undefined: cycle counter removed; acr_cts stays CTS_IDEAL, acr_valid still pulses per wrap event.

## Structure
- Package hdmi_tx_pkg: vic_timing_t struct, timing lookup function by VIC, N lookup, CTS_IDEAL function (real arithmetic, rounded).
- Sub-module hdmi_tx_acr: audio counter, cycle counter, capture register.

## Test plan
- Elaborate AUDIO_RATE 48000 at VIC1/59.94, VIC1/60, VIC4/59.94, VIC16/60, VIC17/60 -> acr_n 6144 each; acr_cts after reset 25175, 25200, 74176, 148500, 27000.
- VIC1 free-run -> cx wraps 799→0, cy wraps 524→0; hsync low exactly cx 656..751; vsync low cy 490..491; video_active for 640×480.
- VIC16 -> hsync high cx 2008..2051, vsync high cy 1084..1088.
- MEASURE_EN, VIC1/60, audio_tick every 525 clocks -> after 48 ticks acr_valid pulse, acr_cts 25200; period 524 -> 25152.
- Assert reset_n mid-measurement -> acr_cts returns to CTS_IDEAL, next capture counts from release.
- AUDIO_RATE 44100, VIC1/60 -> acr_n 6272, acr_cts 28000.
